// File: rtl/sm_move_ctrl.sv
// Step/direction motor move controller.
// Accepts a move command (step count, direction, half-period), holds the
// driver enabled with a stable direction for a setup time, emits the step
// pulses, then reports completion with a one-cycle done pulse.
//
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while idle. The command
// fields are captured on that edge and not looked at again until idle.
//
// All driver outputs are registered so the motor driver never sees decode
// glitches. A SETUP_CYC of 0 skips the setup phase entirely.
module sm_move_ctrl #(
    parameter int SIZE      = 16,
    parameter int DIV_W     = 16,
    parameter int SETUP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SIZE-1:0]  cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_half_period,
    input  logic             abort,
    output logic             drv_step,
    output logic             drv_dir,
    output logic             drv_enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [SIZE-1:0]  steps_done
);

    // The phase timer must hold both the setup length and a half-period.
    localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam int TW = (DIV_W > SW) ? DIV_W : SW;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STEP_HI = 3'd2,
        STEP_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [TW-1:0]     tmr, tmr_n;
    logic [SIZE-1:0]   n_q, n_n;
    logic [DIV_W-1:0]  half_q, half_n;
    logic [DIV_W-1:0]  half_in;
    logic              dir_n;
    logic [SIZE-1:0]   cnt_n;
    logic              abt_n;

    // A requested half-period of zero is run as one cycle.
    assign half_in = (cmd_half_period == '0) ? DIV_W'(1) : cmd_half_period;

    // Next-state, timer, step counter and latched command fields.
    // The timer counts down from (phase length - 1); a phase ends when it is 0.
    // abort has priority over every normal phase exit, so a high phase cut
    // short on its last cycle is still not counted.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        n_n     = n_q;
        half_n  = half_q;
        dir_n   = drv_dir;
        cnt_n   = steps_done;
        abt_n   = aborted;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    n_n    = cmd_steps;
                    half_n = half_in;
                    dir_n  = cmd_dir;
                    cnt_n  = '0;
                    abt_n  = 1'b0;
                    if (cmd_steps == '0) begin
                        state_n = DONE;
                    end else if (SETUP_CYC == 0) begin
                        state_n = STEP_HI;
                        tmr_n   = TW'(half_in - 1'b1);
                    end else begin
                        state_n = SETUP;
                        tmr_n   = TW'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_n = DONE;
                    abt_n   = 1'b1;
                end else if (tmr == '0) begin
                    state_n = STEP_HI;
                    tmr_n   = TW'(half_q - 1'b1);
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            STEP_HI: begin
                if (abort) begin
                    state_n = DONE;
                    abt_n   = 1'b1;
                end else if (tmr == '0) begin
                    state_n = STEP_LO;
                    tmr_n   = TW'(half_q - 1'b1);
                    cnt_n   = steps_done + 1'b1;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            STEP_LO: begin
                if (abort) begin
                    state_n = DONE;
                    abt_n   = 1'b1;
                end else if (tmr == '0) begin
                    if (steps_done == n_q) begin
                        state_n = DONE;
                    end else begin
                        state_n = STEP_HI;
                        tmr_n   = TW'(half_q - 1'b1);
                    end
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, timer, latched command and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tmr        <= '0;
            n_q        <= '0;
            half_q     <= DIV_W'(1);
            drv_dir    <= 1'b0;
            steps_done <= '0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            n_q        <= n_n;
            half_q     <= half_n;
            drv_dir    <= dir_n;
            steps_done <= cnt_n;
            aborted    <= abt_n;
        end
    end

    // Registered decode of the next state into the driver and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drv_step   <= 1'b0;
            drv_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            drv_step   <= (state_n == STEP_HI);
            drv_enable <= (state_n == SETUP) || (state_n == STEP_HI) || (state_n == STEP_LO);
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            cmd_ready  <= (state_n == IDLE);
        end
    end

endmodule
